// File: rtl/oc8051_div_ctrl.sv
// oc8051_div_ctrl: sequencer for the ALU's iterative 8-bit DIV AB unit.
// Latches operands, runs the divider for DIV_CYCLES edges, hands results to writeback.
module oc8051_div_ctrl #(
   parameter int DIV_CYCLES  = 4,
   parameter bit ZERO_BYPASS = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] acc_in,
   input  logic [7:0] b_in,
   output logic       busy,
   output logic       div_rst,
   output logic       div_enable,
   output logic [7:0] div_src1,
   output logic [7:0] div_src2,
   input  logic [7:0] div_des1,
   input  logic [7:0] div_des2,
   input  logic       div_ov,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] acc_out,
   output logic [7:0] b_out,
   output logic       ov_out,
   output logic       cy_out
);

   // Counter runs 0..3; the divider's own iteration count is fixed at four.
   localparam logic [1:0] LP_CNT_LAST = 2'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_cnt;

   logic [7:0] r_src1;
   logic [7:0] r_src2;
   logic [7:0] r_acc;
   logic [7:0] r_b;
   logic       r_ov;

   logic       w_zero;
   logic       w_bypass;
   logic       w_take;
   logic       w_last;
   logic       w_capture;

   assign w_zero    = (b_in == 8'h00);
   assign w_bypass  = ZERO_BYPASS && w_zero;
   assign w_take    = (r_state == IDLE) && start;
   assign w_last    = (r_cnt == LP_CNT_LAST);
   assign w_capture = (r_state == RUN) && w_last;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: a zero divisor may skip the divider entirely.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_next = w_bypass ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Iteration counter, restarted on every accepted request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 2'd0;
      end else if (w_take) begin
         r_cnt <= 2'd0;
      end else if (r_state == RUN) begin
         r_cnt <= r_cnt + 2'd1;
      end
   end

   // Operands stay frozen for the whole divider run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_src1 <= 8'h00;
         r_src2 <= 8'h00;
      end else if (w_take && !w_bypass) begin
         r_src1 <= acc_in;
         r_src2 <= b_in;
      end
   end

   // Result capture; bypass reproduces the divider's zero-divisor answer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= 8'h00;
         r_b   <= 8'h00;
         r_ov  <= 1'b0;
      end else if (w_take && w_bypass) begin
         r_acc <= 8'hFF;
         r_b   <= acc_in;
         r_ov  <= 1'b1;
      end else if (w_capture) begin
         r_acc <= div_des2;
         r_b   <= div_des1;
         r_ov  <= div_ov;
      end
   end

   assign busy       = (r_state != IDLE);
   assign div_rst    = !rst;
   assign div_enable = (r_state == RUN);
   assign res_valid  = (r_state == DONE);
   assign div_src1   = r_src1;
   assign div_src2   = r_src2;
   assign acc_out    = r_acc;
   assign b_out      = r_b;
   assign ov_out     = r_ov;
   assign cy_out     = 1'b0;

endmodule

// File: doc/oc8051_div_ctrl.md
Name: oc8051_div_ctrl

Overview:
Sequencer for the ALU's 4-cycle iterative 8-bit divider (DIV AB), sitting directly upstream of it and consuming its results.
- Accepts a divide request with ACC/B operands, holds them stable, and drives the divider enable for exactly four consecutive cycles.
- Captures quotient, remainder and overflow, then presents them to ACC/B/PSW writeback through a valid/ready handshake.
- Bypasses the divider on divide-by-zero.

Parameters:
DIV_CYCLES, 4, number of enabled divider cycles per operation; must equal the divider's iteration count; only 4 is supported.
ZERO_BYPASS, 1, 1 = B==0 skips the divider and finishes in 1 cycle; 0 = B==0 runs the full 4 cycles.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  divide request; sampled only in IDLE
acc_in  in  8  dividend (ACC)
b_in  in  8  divisor (B)
busy  out  1  high whenever state != IDLE
div_rst  out  1  active-high reset to divider; combinationally equal to !rst
div_enable  out  1  divider enable / cycle advance
div_src1  out  8  latched dividend to divider
div_src2  out  8  latched divisor to divider
div_des1  in  8  divider remainder
div_des2  in  8  divider quotient
div_ov  in  1  divider overflow (divisor == 0)
res_valid  out  1  result available
res_ready  in  1  writeback accepts result
acc_out  out  8  quotient
b_out  out  8  remainder
ov_out  out  1  PSW.OV
cy_out  out  1  PSW.CY; always 0

Behaviour:
Reset (rst=0, async):
- state=IDLE, cnt=0.
- div_src1, div_src2, acc_out, b_out = 8'h00.
- busy, div_enable, res_valid, ov_out, cy_out = 0.
- div_rst=1 for the whole reset duration, so the divider's cycle counter returns to 0.

States:
IDLE:
- start=1 with b_in!=0, or with ZERO_BYPASS=0: latch acc_in->div_src1 and b_in->div_src2; go to RUN with cnt=0.
- start=1 with b_in==0 and ZERO_BYPASS=1: load acc_out=8'hFF, b_out=acc_in, ov_out=1; go to DONE. div_enable never asserts.
RUN:
- div_enable=1 combinationally for all four RUN cycles; cnt increments 0..3.
- At the edge with cnt==3: capture acc_out=div_des2, b_out=div_des1, ov_out=div_ov; go to DONE.
- div_src1/div_src2 are held constant throughout RUN.
DONE:
- res_valid=1; outputs held stable until res_valid && res_ready.
- On that transfer: go to IDLE; res_valid drops the next cycle.

Cycle-level and arithmetic rules:
- Latency from the start-sampling edge to res_valid high: 4 cycles (RUN), or 1 cycle (bypass).
- The divider sees exactly 4 enabled edges per operation, leaving its internal counter at 0 for the next operation.
- Bypass values equal what the divider produces for a zero divisor (quotient FF, remainder = dividend).
- cy_out is constant 0 outside reset.
- ov_out = 1 iff the divisor was 0.

Boundary conditions:
- start while busy (RUN/DONE) is ignored; no queueing. The requester holds start until busy is seen.
- start in the same cycle DONE completes its transfer is ignored, because busy is still high. Back-to-back throughput is therefore one operation per 6 cycles.
- res_ready is ignored outside DONE.
- Reset mid-RUN or mid-DONE abandons the operation with no result. The divider is reset simultaneously via div_rst.

Test Plan:
- acc=251 (0xFB), b=10, start 1 cycle, res_ready=1 -> div_enable high exactly 4 cycles; res_valid 4 cycles after start sample; acc_out=0x19, b_out=0x01, ov_out=0, cy_out=0.
- acc=0xFF, b=0x01 -> acc_out=0xFF, b_out=0x00, ov_out=0.
- acc=0x37, b=0x00, ZERO_BYPASS=1 -> res_valid 1 cycle after start, div_enable never high, acc_out=0xFF, b_out=0x37, ov_out=1. Repeat with ZERO_BYPASS=0 -> same values after 4 cycles.
- Backpressure: acc=0x64, b=0x07, res_ready low for 3 DONE cycles, start pulsed during DONE -> outputs held at 0x0E/0x02, res_valid steady, second start ignored, busy high until transfer.
- Reset mid-operation: rst low during RUN cnt=2 -> all outputs 0 and div_rst=1 immediately; after release, run acc=0x64, b=0x07 -> correct 0x0E/0x02, proving the divider counter resynchronised.
- Back-to-back: two requests (200/3, 9/9) issued as soon as busy falls -> 0x42/0x02 then 0x01/0x00, each with exactly 4 div_enable cycles.
